muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/HI/LO width (even, >=8).
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1, divider iteration counter width.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 valid  input  1  func/operands valid this cycle.
REQ-006 func  input  6  R-type func: 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu.
REQ-007 src_a, src_b  input  DATA_W each  rs and rt operands.
REQ-008 flush  input  1  abort in-flight operation.
REQ-009 busy  output  1  unit occupied; upstream stalls.
REQ-010 done  output  1  one-cycle pulse when HI/LO updated by mult/div.
REQ-011 result  output  DATA_W  mfhi/mflo read data.
REQ-012 hi, lo  output  DATA_W each  architectural HI/LO registers.

Function
REQ-013 States IDLE, MUL, DIV, FIN; busy = (state != IDLE), combinational.
REQ-014 valid accepted only in IDLE; valid while busy ignored, no state change.
REQ-015 Non-listed func with valid: ignored, no state or register change.
REQ-016 mfhi/mflo in IDLE: result = hi/lo combinationally, same cycle; otherwise result = 0.
REQ-017 mthi/mtlo in IDLE: hi/lo <= src_a at next edge; no busy, no done.
REQ-018 mult/multu: IDLE->MUL on accept; MUL registers 2*DATA_W product (signed for mult, unsigned for multu); MUL->FIN next cycle.
REQ-019 div/divu: IDLE->DIV; restoring divide on operand magnitudes, one quotient bit per cycle, exactly DATA_W cycles in DIV; then FIN.
REQ-020 Signed div: quotient truncates toward zero; remainder sign equals dividend sign; negation applied in FIN.
REQ-021 Most-negative / -1 (signed): LO = most-negative value, HI = 0.
REQ-022 Divisor zero: LO = all ones, HI = src_a; no exception raised.
REQ-023 FIN: hi <= upper half/remainder, lo <= lower half/quotient, done = 1, FIN->IDLE.
REQ-024 Latency from accept edge: mult done in cycle 2; div done in cycle DATA_W+1.
REQ-025 Operands captured at accept; later src_a/src_b changes have no effect.
REQ-026 flush in any state: next state IDLE, hi/lo unchanged, done not asserted; flush outranks FIN (no HI/LO write when flush coincides with FIN).
REQ-027 flush and valid in same IDLE cycle: valid ignored.
REQ-028 Back-to-back: new op accepted in the cycle after FIN (state IDLE).

Reset
REQ-029 rst_n low: state IDLE, hi = 0, lo = 0, counter 0, internal dividend/divisor/product registers 0, done = 0, busy = 0, result = 0.
REQ-030 Reset mid-operation discards the operation; no done pulse after release.

Configuration
REQ-031 Macro MULDIV_DIV_EARLY_EXIT_EN.
REQ-032 Defined: div/divu with src_a == 0 or src_b == 0 goes IDLE->FIN directly (done in cycle 1), results per REQ-022 or zero quotient/remainder.
REQ-033 Undefined: all divides take full DATA_W cycles; results identical.

Structure
REQ-034 Shared package muldiv_pkg: func code constants, state enum typedef.
REQ-035 Sub-module muldiv_div_core: iterative restoring divider (start, dividend, divisor, busy, quotient, remainder), unsigned only; sign handling stays in muldiv_unit.

Verification
REQ-036 mult 0xFFFFFFFF x 0x00000002 -> done cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 div -7 / 2 -> done cycle 33, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 100/7 -> lo=14, hi=2.
REQ-038 divu 5/0 -> lo=0xFFFFFFFF, hi=5; with MULDIV_DIV_EARLY_EXIT_EN done cycle 1, else cycle 33.
REQ-039 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 Start div, assert flush in cycle 10 -> busy low next cycle, no done, hi/lo keep prior values; new valid in same cycle as flush ignored.
REQ-041 mthi 0x1234 in IDLE, then mfhi -> result=0x1234 same cycle; mfhi while busy -> result=0, ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: func codes and FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1a;
    localparam logic [5:0] FUNC_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
// Latency: first bit resolved on the start edge, busy for DATA_W-1 cycles after it.
// Backpressure: none; start restarts unconditionally, flush abandons the divide.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] cur_rem;
    logic [DATA_W-1:0] cur_quo;
    logic [DATA_W-1:0] cur_dvs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] nxt_rem;
    logic [DATA_W-1:0] nxt_quo;

    // One restoring step; on start it works straight from the new operands so the
    // first bit lands on the start edge and the remaining bits follow one per cycle.
    always_comb begin
        cur_rem = start ? '0 : rem_q;
        cur_quo = start ? dividend : quo_q;
        cur_dvs = start ? divisor : dvs_q;
        shifted = {cur_rem, cur_quo[DATA_W-1]};
        diff    = shifted - {1'b0, cur_dvs};
        if (diff[DATA_W]) begin
            nxt_rem = shifted[DATA_W-1:0];
            nxt_quo = {cur_quo[DATA_W-2:0], 1'b0};
        end else begin
            nxt_rem = diff[DATA_W-1:0];
            nxt_quo = {cur_quo[DATA_W-2:0], 1'b1};
        end
    end

    // Iteration state: quotient bits shift in from the bottom as dividend bits shift out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(DATA_W - 1);
        end else if (cnt_q != '0) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy      = (cnt_q != '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit with mfhi/mthi/mflo/mtlo; optional MULDIV_DIV_EARLY_EXIT_EN.
// Latency: mult done in cycle 2, div in cycle DATA_W+1 (cycle 1 on zero operand with early exit).
// Backpressure: busy high outside IDLE; valid is ignored then, upstream must stall.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_t state;
    state_t next_state;

    logic acc_mul;
    logic acc_div;
    logic wr_hi;
    logic wr_lo;
    logic rd_hi;
    logic rd_lo;
    logic zero_exit;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                op_signed;
    logic [2*DATA_W-1:0] prod;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;

    logic                div_signed;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                div_start;
    logic                div_busy;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic [DATA_W-1:0]   fix_q;
    logic [DATA_W-1:0]   fix_r;
    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] mul_full;

`ifdef MULDIV_DIV_EARLY_EXIT_EN
    assign zero_exit = (src_a == '0) || (src_b == '0);
`else
    assign zero_exit = 1'b0;
`endif

    // Divider operands as magnitudes; signs are remembered and reapplied in FIN.
    // A zero divisor keeps the all-ones quotient unnegated so LO reads all ones.
    assign div_signed = (func == FUNC_DIV);
    assign a_neg      = div_signed && src_a[DATA_W-1];
    assign b_neg      = div_signed && src_b[DATA_W-1];
    assign mag_a      = a_neg ? ('0 - src_a) : src_a;
    assign mag_b      = b_neg ? ('0 - src_b) : src_b;
    assign div_start  = acc_div && !zero_exit;
    assign fix_q      = neg_q ? ('0 - quotient) : quotient;
    assign fix_r      = neg_r ? ('0 - remainder) : remainder;

    // Sign- or zero-extend to full width so one multiplier serves mult and multu.
    assign ext_a    = op_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
    assign ext_b    = op_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
    assign mul_full = ext_a * ext_b;

    muldiv_div_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .flush     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and command decode; requests are only honoured in IDLE without flush.
    always_comb begin
        next_state = state;
        acc_mul    = 1'b0;
        acc_div    = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        rd_hi      = 1'b0;
        rd_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (valid && !flush) begin
                    case (func)
                        FUNC_MFHI: rd_hi = 1'b1;
                        FUNC_MFLO: rd_lo = 1'b1;
                        FUNC_MTHI: wr_hi = 1'b1;
                        FUNC_MTLO: wr_lo = 1'b1;
                        FUNC_MULT, FUNC_MULTU: begin
                            acc_mul    = 1'b1;
                            next_state = MUL;
                        end
                        FUNC_DIV, FUNC_DIVU: begin
                            acc_div    = 1'b1;
                            next_state = zero_exit ? FIN : DIV;
                        end
                        default: ;
                    endcase
                end
            end
            MUL:     next_state = FIN;
            DIV:     next_state = div_busy ? DIV : FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == FIN) && !flush;
    assign result = rd_hi ? hi : (rd_lo ? lo : '0);

    // Operand capture, product register and architectural HI/LO updates.
    // Early-exit divides stage their answer in the product register so FIN treats them like a mult.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            prod      <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (acc_mul) begin
                op_a      <= src_a;
                op_b      <= src_b;
                op_signed <= (func == FUNC_MULT);
                is_div    <= 1'b0;
            end
            if (acc_div) begin
                is_div <= !zero_exit;
                neg_q  <= (a_neg ^ b_neg) && (src_b != '0);
                neg_r  <= a_neg;
                if (zero_exit) begin
                    prod <= (src_b == '0) ? {src_a, {DATA_W{1'b1}}} : '0;
                end
            end
            if (state == MUL) begin
                prod <= mul_full;
            end
            if (done) begin
                hi <= is_div ? fix_r : prod[2*DATA_W-1:DATA_W];
                lo <= is_div ? fix_q : prod[DATA_W-1:0];
            end
            if (wr_hi) begin
                hi <= src_a;
            end
            if (wr_lo) begin
                lo <= src_a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit with a queue scoreboard and arithmetic reference model.
// Latency: checks done timing per op against the expected cycle count.
// Backpressure: driver waits for busy low before every issue.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [5:0]   func  = '0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid),
        .func   (func),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [5:0]   ftab[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] h, output logic [W-1:0] l, output int lat);
        longint       sa;
        longint       sb_v;
        logic [63:0]  p;
        logic [63:0]  q;
        logic [63:0]  r;
        sa   = $signed(a);
        sb_v = $signed(b);
        h    = m_hi;
        l    = m_lo;
        lat  = 0;
        if (f == F_MULT || f == F_MULTU) begin
            if (f == F_MULT) p = sa * sb_v;
            else             p = {32'b0, a} * {32'b0, b};
            h   = p[63:32];
            l   = p[31:0];
            lat = 2;
        end else if (f == F_DIV || f == F_DIVU) begin
            if (b == 0) begin
                l = '1;
                h = a;
            end else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = '0;
            end else if (f == F_DIV) begin
                q = sa / sb_v;
                r = sa % sb_v;
                l = q[31:0];
                h = r[31:0];
            end else begin
                l = a / b;
                h = a % b;
            end
`ifdef MULDIV_DIV_EARLY_EXIT_EN
            lat = (a == 0 || b == 0) ? 1 : W + 1;
`else
            lat = W + 1;
`endif
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("busy_timeout", {63'b0, busy}, 64'd0);
    endtask

    // Issue one request; when expect_done is set the expected HI/LO goes to the scoreboard.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_done);
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic [W-1:0] exp_res;
        int           lat;
        bit           long_op;
        exp_t         e;
        string        nm;
        @(negedge clk);
        wait_idle();
        nm      = $sformatf("f%02h_%h_%h", f, a, b);
        long_op = (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
        exp_res = (f == F_MFHI) ? m_hi : ((f == F_MFLO) ? m_lo : '0);
        valid = 1'b1;
        func  = f;
        src_a = a;
        src_b = b;
        ref_op(f, a, b, h, l, lat);
        if (long_op && expect_done) begin
            e = '{h, l, lat, cyc, nm};
            sb.push_back(e);
            m_hi = h;
            m_lo = l;
        end
        if (f == F_MTHI) m_hi = a;
        if (f == F_MTLO) m_lo = a;
        #1;
        check({nm, " result"}, result, exp_res);
        @(posedge clk);
        #1;
        valid = 1'b0;
        func  = '0;
        src_a = $urandom;
        src_b = $urandom;
        check({nm, " busy"}, {63'b0, busy}, {63'b0, long_op});
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every done pulse pops one expectation, checks latency, then HI/LO after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'b0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
                    @(posedge clk);
                    #1;
                    check({e.name, " hi"}, hi, e.hi);
                    check({e.name, " lo"}, lo, e.lo);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal;
    end

    initial begin
        ftab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO, F_DIV, 6'h05};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset hi", hi, 64'd0);
        check("reset lo", lo, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        issue(F_MULT,  32'hFFFF_FFFF, 32'h2, 1);
        issue(F_MULTU, 32'hFFFF_FFFF, 32'h2, 1);
        issue(F_DIV,   32'hFFFF_FFF9, 32'h2, 1);
        issue(F_DIVU,  32'd100, 32'd7, 1);
        issue(F_DIVU,  32'd5, 32'd0, 1);
        issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1);
        issue(F_DIV,   32'd0, 32'd5, 1);
        issue(F_DIV,   32'hFFFF_FFF7, 32'd0, 1);
        issue(F_DIV,   32'd7, 32'hFFFF_FFFE, 1);
        issue(F_MTHI,  32'h1234, 32'h0, 1);
        issue(F_MFHI,  32'h0, 32'h0, 1);
        issue(F_MTLO,  32'hBEEF, 32'h0, 1);
        issue(F_MFLO,  32'h0, 32'h0, 1);
        issue(6'h00,   32'hAAAA, 32'h5555, 1);
        issue(6'h1c,   32'hAAAA, 32'h5555, 1);

        // mfhi while busy reads zero and is dropped.
        issue(F_DIVU, 32'd1000, 32'd3, 1);
        @(negedge clk);
        valid = 1'b1;
        func  = F_MFHI;
        #1;
        check("mfhi_busy result", result, 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;

        // Flush in cycle 10 of a divide with a competing request.
        issue(F_DIV, 32'd12345, 32'd67, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        valid = 1'b1;
        func  = F_MULT;
        src_a = 32'd9;
        src_b = 32'd9;
        #1;
        check("flush_div done", {63'b0, done}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        check("flush_div busy", {63'b0, busy}, 64'd0);
        check("flush_div hi", hi, m_hi);
        check("flush_div lo", lo, m_lo);
        repeat (40) @(posedge clk);

        // Flush with mthi in IDLE: write dropped.
        @(negedge clk);
        flush = 1'b1;
        valid = 1'b1;
        func  = F_MTHI;
        src_a = 32'hDEAD;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        check("flush_idle hi", hi, m_hi);
        check("flush_idle busy", {63'b0, busy}, 64'd0);

        // Flush landing on FIN of a mult blocks the HI/LO write.
        issue(F_MULT, 32'd3, 32'd5, 0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_fin done", {63'b0, done}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_fin busy", {63'b0, busy}, 64'd0);
        check("flush_fin hi", hi, m_hi);
        check("flush_fin lo", lo, m_lo);

        // Reset during a divide: everything cleared, no done afterwards.
        issue(F_DIVU, 32'd77, 32'd7, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("midreset busy", {63'b0, busy}, 64'd0);
        check("midreset hi", hi, 64'd0);
        check("midreset lo", lo, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            issue(ftab[$urandom_range(0, 9)], pick(), pick(), 1);
        end

        // Drain outstanding expectations.
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
